// File: rtl/ps2_keycode_rx_if.sv
// PS/2 pin inputs and decoded key outputs of ps2_keycode_rx.
// The receiver uses the slave view; the board/bench side uses the master view.
interface ps2_keycode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic [7:0] scan_byte;
  logic       byte_valid;
  logic       frame_error;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output scan_byte,
    output byte_valid,
    output frame_error
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  scan_byte,
    input  byte_valid,
    input  frame_error
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 receiver plus make/break decoder for left/right/space, driving one held-key code.
// byte_valid lands 1 cycle after the stop-bit edge and keycode 1 cycle later; there is no backpressure.
module ps2_keycode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  KC_LEFT        = 8'd80,
  parameter logic [7:0]  KC_RIGHT       = 8'd79,
  parameter logic [7:0]  KC_SPACE       = 8'd44
) (
  input logic             Clk,
  input logic             Reset,
  ps2_keycode_rx_if.slave ps2_if
);

  localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Input conditioning
  logic ps2_clk_s1_q;
  logic ps2_clk_s2_q;
  logic ps2_clk_dly_q;
  logic ps2_dat_s1_q;
  logic ps2_dat_s2_q;
  logic fall_edge;
  logic rx_bit;

  // Synchronizers idle at 1 so leaving reset never fabricates a falling edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ps2_clk_s1_q  <= 1'b1;
      ps2_clk_s2_q  <= 1'b1;
      ps2_clk_dly_q <= 1'b1;
      ps2_dat_s1_q  <= 1'b1;
      ps2_dat_s2_q  <= 1'b1;
    end else begin
      ps2_clk_s1_q  <= ps2_if.ps2_clk;
      ps2_clk_s2_q  <= ps2_clk_s1_q;
      ps2_clk_dly_q <= ps2_clk_s2_q;
      ps2_dat_s1_q  <= ps2_if.ps2_data;
      ps2_dat_s2_q  <= ps2_dat_s1_q;
    end
  end

  assign fall_edge = ps2_clk_dly_q & ~ps2_clk_s2_q;
  assign rx_bit    = ps2_dat_s2_q;

  // Frame FSM
  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frm_state_e;

  frm_state_e      frm_state_q;
  frm_state_e      frm_state_d;
  logic [2:0]      bit_cnt_q;
  logic [2:0]      bit_cnt_d;
  logic [7:0]      shift_q;
  logic [7:0]      shift_d;
  logic            parity_q;
  logic            parity_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic [7:0]      scan_byte_q;
  logic [7:0]      scan_byte_d;
  logic            byte_valid_q;
  logic            byte_valid_d;
  logic            frame_error_q;
  logic            frame_error_d;
  logic            frame_good;

  // Stop bit must be 1 and data plus parity must carry odd weight.
  assign frame_good = rx_bit & (^{shift_q, parity_q});

  always_comb begin
    frm_state_d   = frm_state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    to_cnt_d      = '0;
    scan_byte_d   = scan_byte_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    if (frm_state_q != F_IDLE && !fall_edge) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (frm_state_q)
      F_IDLE: begin
        if (fall_edge) begin
          if (!rx_bit) begin
            frm_state_d = F_DATA;
            bit_cnt_d   = 3'd0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      F_DATA: begin
        if (fall_edge) begin
          shift_d   = {rx_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            frm_state_d = F_PARITY;
          end
        end
      end
      F_PARITY: begin
        if (fall_edge) begin
          parity_d    = rx_bit;
          frm_state_d = F_STOP;
        end
      end
      F_STOP: begin
        if (fall_edge) begin
          if (frame_good) begin
            scan_byte_d  = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          frm_state_d = F_IDLE;
        end
      end
      default: frm_state_d = F_IDLE;
    endcase

    // A stalled keyboard clock abandons the frame; any real edge restarts the count first.
    if (frm_state_q != F_IDLE && !fall_edge && to_cnt_q == TO_LAST) begin
      frm_state_d   = F_IDLE;
      frame_error_d = 1'b1;
      to_cnt_d      = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frm_state_q   <= F_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      scan_byte_q   <= 8'd0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frm_state_q   <= frm_state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      to_cnt_q      <= to_cnt_d;
      scan_byte_q   <= scan_byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Decode FSM: prefix bytes E0/F0 qualify the following byte
  typedef enum logic [1:0] {
    D_NORM,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_e;

  dec_state_e dec_state_q;
  dec_state_e dec_state_d;
  logic       mk_left;
  logic       mk_right;
  logic       mk_space;
  logic       brk_left;
  logic       brk_right;
  logic       brk_space;

  always_comb begin
    dec_state_d = dec_state_q;
    mk_left     = 1'b0;
    mk_right    = 1'b0;
    mk_space    = 1'b0;
    brk_left    = 1'b0;
    brk_right   = 1'b0;
    brk_space   = 1'b0;

    if (byte_valid_q) begin
      case (dec_state_q)
        D_NORM: begin
          if (scan_byte_q == SC_EXT) begin
            dec_state_d = D_EXT;
          end else if (scan_byte_q == SC_BREAK) begin
            dec_state_d = D_BRK;
          end else begin
            mk_space = (scan_byte_q == SC_SPACE);
          end
        end
        D_EXT: begin
          dec_state_d = D_NORM;
          if (scan_byte_q == SC_BREAK) begin
            dec_state_d = D_EXT_BRK;
          end else begin
            mk_left  = (scan_byte_q == SC_LEFT);
            mk_right = (scan_byte_q == SC_RIGHT);
          end
        end
        D_BRK: begin
          dec_state_d = D_NORM;
          brk_space   = (scan_byte_q == SC_SPACE);
        end
        D_EXT_BRK: begin
          dec_state_d = D_NORM;
          brk_left    = (scan_byte_q == SC_LEFT);
          brk_right   = (scan_byte_q == SC_RIGHT);
        end
        default: dec_state_d = D_NORM;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dec_state_q <= D_NORM;
    end else begin
      dec_state_q <= dec_state_d;
    end
  end

  // Key tracking
  logic       held_left_q;
  logic       held_left_d;
  logic       held_right_q;
  logic       held_right_d;
  logic       held_space_q;
  logic       held_space_d;
  logic [7:0] keycode_q;
  logic [7:0] keycode_d;
  logic       active_broken;

  function automatic logic [7:0] top_held(input logic l, input logic r, input logic s);
    logic [7:0] code;
    code = 8'd0;
    if (l) begin
      code = KC_LEFT;
    end else if (r) begin
      code = KC_RIGHT;
    end else if (s) begin
      code = KC_SPACE;
    end
    return code;
  endfunction

  assign active_broken = (brk_left  && keycode_q == KC_LEFT)  ||
                         (brk_right && keycode_q == KC_RIGHT) ||
                         (brk_space && keycode_q == KC_SPACE);

  always_comb begin
    held_left_d  = held_left_q  & ~brk_left;
    held_right_d = held_right_q & ~brk_right;
    held_space_d = held_space_q & ~brk_space;
    keycode_d    = keycode_q;

    if (mk_left) begin
      held_left_d = 1'b1;
      keycode_d   = KC_LEFT;
    end else if (mk_right) begin
      held_right_d = 1'b1;
      keycode_d    = KC_RIGHT;
    end else if (mk_space) begin
      held_space_d = 1'b1;
      keycode_d    = KC_SPACE;
    end else if (active_broken) begin
      // Fall back to the highest-priority key still down.
      keycode_d = top_held(held_left_d, held_right_d, held_space_d);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_left_q  <= 1'b0;
      held_right_q <= 1'b0;
      held_space_q <= 1'b0;
      keycode_q    <= 8'd0;
    end else begin
      held_left_q  <= held_left_d;
      held_right_q <= held_right_d;
      held_space_q <= held_space_d;
      keycode_q    <= keycode_d;
    end
  end

  assign ps2_if.keycode     = keycode_q;
  assign ps2_if.scan_byte   = scan_byte_q;
  assign ps2_if.byte_valid  = byte_valid_q;
  assign ps2_if.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Randomized PS/2 frame stimulus checked every cycle against a queue-based frame/decode model.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;
  localparam int TO = 200;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  ps2_keycode_rx_if tif();

  ps2_keycode_rx #(
    .TIMEOUT_CYCLES(TO),
    .KC_LEFT(8'd80),
    .KC_RIGHT(8'd79),
    .KC_SPACE(8'd44)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ps2_if(tif)
  );

  int checks = 0;
  int errors = 0;

  // Expected outcome of each frame in send order: bit 8 set = error, else good byte [7:0].
  logic [8:0] exp_q[$];
  logic [7:0] m_kc = 8'd0;
  logic [7:0] m_scan = 8'd0;
  bit         m_ext = 0;
  bit         m_brk = 0;
  bit         m_held[3] = '{0, 0, 0};
  int         n_valid = 0;
  int         n_err = 0;
  logic       rst_edge;
  int         half = 6;
  logic [7:0] pool[10] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h29, 8'h6B, 8'h74, 8'h6B, 8'hAA, 8'h12};

  always @(posedge Clk) rst_edge <= Reset;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Key index 0=left, 1=right, 2=space, also the priority order.
  function automatic logic [7:0] code_of(input int k);
    return (k == 0) ? 8'd80 : (k == 1) ? 8'd79 : 8'd44;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    bit is_brk;
    k = -1;
    is_brk = m_brk;
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'h29) k = 2;
    end else if (m_ext && !m_brk && b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_ext) begin
        if (b == 8'h6B) k = 0;
        else if (b == 8'h74) k = 1;
      end else if (b == 8'h29) begin
        k = 2;
      end
      m_ext = 0;
      m_brk = 0;
    end
    if (k >= 0) begin
      if (!is_brk) begin
        m_held[k] = 1;
        m_kc = code_of(k);
      end else begin
        m_held[k] = 0;
        if (m_kc == code_of(k)) begin
          m_kc = 8'd0;
          for (int j = 2; j >= 0; j--) if (m_held[j]) m_kc = code_of(j);
        end
      end
    end
  endtask

  always @(negedge Clk) begin
    logic [8:0] ev;
    if (rst_edge === 1'b1) begin
      m_kc = 8'd0; m_scan = 8'd0; m_ext = 0; m_brk = 0;
      for (int j = 0; j < 3; j++) m_held[j] = 0;
      exp_q.delete();
      chk("rst_keycode", 32'(tif.keycode), 32'd0);
      chk("rst_scan_byte", 32'(tif.scan_byte), 32'd0);
      chk("rst_byte_valid", 32'(tif.byte_valid), 32'd0);
      chk("rst_frame_error", 32'(tif.frame_error), 32'd0);
    end else begin
      chk("keycode", 32'(tif.keycode), 32'(m_kc));
      if (tif.byte_valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte_valid", 32'(tif.scan_byte), 32'h1ff);
        end else begin
          ev = exp_q.pop_front();
          chk("event_kind_valid", 32'(tif.byte_valid), 32'(!ev[8]));
          if (!ev[8]) begin
            m_scan = ev[7:0];
            model_byte(ev[7:0]);
          end
        end
      end
      if (tif.frame_error === 1'b1) begin
        n_err++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_error", 32'(tif.frame_error), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("event_kind_error", 32'(tif.frame_error), 32'(ev[8]));
        end
      end
      chk("scan_byte", 32'(tif.scan_byte), 32'(m_scan));
    end
  end

  task automatic ps2_bit(input logic b);
    tif.ps2_data = b;
    repeat (half) @(negedge Clk);
    tif.ps2_clk = 1'b0;
    repeat (half) @(negedge Clk);
    tif.ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                          input int nbits);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    tif.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    send_raw(b, 1'b0, 1'b1, 11);
    repeat (4) @(negedge Clk);
  endtask

  task automatic send_bad(input logic [7:0] b, input logic par_flip, input logic stop_bit);
    exp_q.push_back(9'h100);
    send_raw(b, par_flip, stop_bit, 11);
    repeat (4) @(negedge Clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    chk("drain_pending_events", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge Clk);
  endtask

  task automatic seq_kc(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int n, input logic [7:0] exp_kc);
    send_byte(b0);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    drain();
    chk({nm, "_dut"}, 32'(tif.keycode), 32'(exp_kc));
    chk({nm, "_model"}, 32'(m_kc), 32'(exp_kc));
  endtask

  initial begin
    int e0;
    int v0;
    int r;
    tif.ps2_clk = 1'b1;
    tif.ps2_data = 1'b1;
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    chk("reset_keycode", 32'(tif.keycode), 32'd0);
    chk("reset_scan_byte", 32'(tif.scan_byte), 32'd0);
    chk("reset_byte_valid", 32'(tif.byte_valid), 32'd0);
    chk("reset_frame_error", 32'(tif.frame_error), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    seq_kc("space_make", 8'h29, 8'h00, 8'h00, 1, 8'd44);
    chk("space_scan_byte", 32'(tif.scan_byte), 32'h29);
    chk("space_valid_count", 32'(n_valid), 32'd1);
    seq_kc("space_break", 8'hF0, 8'h29, 8'h00, 2, 8'd0);

    seq_kc("left_make", 8'hE0, 8'h6B, 8'h00, 2, 8'd80);
    seq_kc("right_make", 8'hE0, 8'h74, 8'h00, 2, 8'd79);
    seq_kc("right_break", 8'hE0, 8'hF0, 8'h74, 3, 8'd80);
    seq_kc("space_over_left", 8'h29, 8'h00, 8'h00, 1, 8'd44);
    seq_kc("left_again", 8'hE0, 8'h6B, 8'h00, 2, 8'd80);
    seq_kc("left_break_to_space", 8'hE0, 8'hF0, 8'h6B, 3, 8'd44);
    seq_kc("release_all", 8'hF0, 8'h29, 8'h00, 2, 8'd0);

    // Parity error in the middle of an E0 6B sequence: lost byte, prefix state kept.
    e0 = n_err; v0 = n_valid;
    send_byte(8'hE0);
    send_bad(8'h29, 1'b1, 1'b1);
    drain();
    chk("parity_err_count", 32'(n_err), 32'(e0 + 1));
    chk("parity_no_valid", 32'(n_valid), 32'(v0 + 1));
    chk("parity_kc_kept", 32'(tif.keycode), 32'd0);
    seq_kc("ext_after_error", 8'h6B, 8'h00, 8'h00, 1, 8'd80);
    seq_kc("left_release", 8'hE0, 8'hF0, 8'h6B, 3, 8'd0);

    // Keyboard clock stalls after four data bits.
    e0 = n_err;
    exp_q.push_back(9'h100);
    send_raw(8'h29, 1'b0, 1'b1, 5);
    drain();
    chk("timeout_err_count", 32'(n_err), 32'(e0 + 1));
    seq_kc("after_timeout", 8'h29, 8'h00, 8'h00, 1, 8'd44);

    // Reset during a partial frame while space is held.
    e0 = n_err;
    send_raw(8'h29, 1'b0, 1'b1, 5);
    tif.ps2_data = 1'b1;
    repeat (half) @(negedge Clk);
    tif.ps2_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    tif.ps2_clk = 1'b1;
    tif.ps2_data = 1'b1;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("midreset_keycode", 32'(tif.keycode), 32'd0);
    chk("midreset_scan", 32'(tif.scan_byte), 32'd0);
    chk("midreset_no_err", 32'(n_err), 32'(e0));

    v0 = n_valid;
    seq_kc("ignored_bat_ack", 8'hAA, 8'hFA, 8'hE0, 3, 8'd0);
    seq_kc("ignored_ext12", 8'h12, 8'h00, 8'h00, 1, 8'd0);
    chk("ignored_valid_count", 32'(n_valid), 32'(v0 + 4));
    seq_kc("break_unheld", 8'hE0, 8'hF0, 8'h6B, 3, 8'd0);

    // Random traffic with occasional parity, stop and start-bit faults.
    for (int n = 0; n < 140; n++) begin
      half = $urandom_range(3, 9);
      r = $urandom_range(0, 99);
      if (r < 8) begin
        send_bad(pool[$urandom_range(0, 9)], 1'b1, 1'b1);
      end else if (r < 12) begin
        send_bad(pool[$urandom_range(0, 9)], 1'b0, 1'b0);
      end else if (r < 15) begin
        exp_q.push_back(9'h100);
        ps2_bit(1'b1);
        repeat (4) @(negedge Clk);
      end else begin
        send_byte(pool[$urandom_range(0, 9)]);
      end
      repeat ($urandom_range(0, 20)) @(negedge Clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
